// File: rtl/wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wash_cycle_ctrl
// Brief    : Parametrised wash-cycle sequencer. Steps through NUM_STAGES
//            programme stages whose durations are snapshotted at start, with
//            pause/resume, door interlock and abort. The stage code drives
//            the motor/valve decoders downstream.
// Revision : 1.0 - initial release
// ============================================================================
module wash_cycle_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 4,
    parameter int STAGE_W    = $clog2(NUM_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        abort,
    input  logic                        door_closed,
    input  logic [NUM_STAGES*CNT_W-1:0] stage_time,
    output logic [STAGE_W-1:0]          stage,
    output logic [CNT_W-1:0]            remaining,
    output logic                        busy,
    output logic                        paused,
    output logic                        done,
    output logic                        aborted
);

    localparam int TIME_W = NUM_STAGES * CNT_W;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Stage code reported while no programme is active
    localparam logic [STAGE_W-1:0] IDLE_CODE  = {STAGE_W{1'b1}};
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    // ------------------------------------------------------------------------
    // Residual-counter load value for stage idx: D-1, or 0 when D is 0, so a
    // zero-length stage still occupies one RUN cycle.
    // ------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] load_val(
        input logic [TIME_W-1:0]  times,
        input logic [STAGE_W-1:0] idx
    );
        logic [CNT_W-1:0] dur;
        dur = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == STAGE_W'(i)) begin
                dur = times[i*CNT_W +: CNT_W];
            end
        end
        return (dur != '0) ? (dur - CNT_W'(1)) : '0;
    endfunction

    logic [1:0]         state_q,     state_d;
    logic [STAGE_W-1:0] stage_q,     stage_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [TIME_W-1:0]  times_q,     times_d;
    logic               busy_q,      busy_d;
    logic               paused_q,    paused_d;
    logic               done_q,      done_d;
    logic               aborted_q,   aborted_d;

    // Pause request and open door both freeze a running programme
    logic hold_req;
    assign hold_req = pause | ~door_closed;

    // Next-state logic; priority abort > hold > stage expiry > start
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        remaining_d = remaining_q;
        times_d     = times_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Start is level-sensitive and never latched while blocked
                if (start && door_closed && !pause && !abort) begin
                    state_d     = ST_RUN;
                    times_d     = stage_time;
                    stage_d     = '0;
                    remaining_d = load_val(stage_time, '0);
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    stage_d     = IDLE_CODE;
                    remaining_d = '0;
                    aborted_d   = 1'b1;
                end else if (hold_req) begin
                    // Stage and residual are held, even if the stage was
                    // about to expire this cycle.
                    state_d = ST_PAUSE;
                end else if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end else if (stage_q < LAST_STAGE) begin
                    stage_d     = stage_q + STAGE_W'(1);
                    remaining_d = load_val(times_q, stage_q + STAGE_W'(1));
                end else begin
                    state_d     = ST_IDLE;
                    stage_d     = IDLE_CODE;
                    remaining_d = '0;
                    done_d      = 1'b1;
                end
            end

            ST_PAUSE: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    stage_d     = IDLE_CODE;
                    remaining_d = '0;
                    aborted_d   = 1'b1;
                end else if (start && !pause && door_closed) begin
                    // Resume continues from the held residual, no reload
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Unused encoding: recover silently to idle
                state_d     = ST_IDLE;
                stage_d     = IDLE_CODE;
                remaining_d = '0;
            end
        endcase

        busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        paused_d = (state_d == ST_PAUSE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stage_q     <= IDLE_CODE;
            remaining_q <= '0;
            times_q     <= '0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            remaining_q <= remaining_d;
            times_q     <= times_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign stage     = stage_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_wash_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_cycle_ctrl
// Brief    : Directed, table-driven bench for wash_cycle_ctrl
//            (NUM_STAGES=5, CNT_W=4, durations {3,1,0,2,4}).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_cycle_ctrl;

    localparam int NS  = 5;
    localparam int CW  = 4;
    localparam int SW  = 3;
    localparam int IDL = 7;

    // Durations D0..D4 = 3,1,0,2,4 packed at [i*4 +: 4]
    localparam logic [NS*CW-1:0] TIMES_STD = 20'h42013;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              pause;
    logic              abort;
    logic              door_closed;
    logic [NS*CW-1:0]  stage_time;
    logic [SW-1:0]     stage;
    logic [CW-1:0]     remaining;
    logic              busy;
    logic              paused;
    logic              done;
    logic              aborted;

    int checks   = 0;
    int failures = 0;

    wash_cycle_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .door_closed (door_closed),
        .stage_time  (stage_time),
        .stage       (stage),
        .remaining   (remaining),
        .busy        (busy),
        .paused      (paused),
        .done        (done),
        .aborted     (aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       pa;
        logic       ab;
        logic       dr;
        logic [2:0] e_stage;
        logic [3:0] e_rem;
        logic       e_busy;
        logic       e_paused;
        logic       e_done;
        logic       e_abort;
    } vec_t;

    vec_t vt[$];

    // Append one vector: inputs for the cycle, then outputs expected after the edge
    task automatic v(input logic s, p, a, d, input int es, er,
                     input logic eb, ep, ed, ea);
        vec_t x;
        x.st = s; x.pa = p; x.ab = a; x.dr = d;
        x.e_stage = es[2:0]; x.e_rem = er[3:0];
        x.e_busy = eb; x.e_paused = ep; x.e_done = ed; x.e_abort = ea;
        vt.push_back(x);
    endtask

    // Running-cycle shorthand: door closed, no controls, RUN expected
    task automatic r(input int es, er);
        v(1'b0, 1'b0, 1'b0, 1'b1, es, er, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [10:0] outs();
        return {stage, remaining, busy, paused, done, aborted};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got stage=%0d rem=%0d busy=%b paused=%b done=%b aborted=%b, expected stage=%0d rem=%0d busy=%b paused=%b done=%b aborted=%b",
                     name, act[10:8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[10:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] pk(input int es, er, input logic b, p, d, a);
        return {es[2:0], er[3:0], b, p, d, a};
    endfunction

    task automatic build_table();
        // Idle guards: door open, then door closing without start, start with pause
        v(1, 0, 0, 0, IDL, 0, 0, 0, 0, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);
        v(1, 1, 0, 1, IDL, 0, 0, 0, 0, 0);

        // A: full uninterrupted programme, 11 RUN cycles then done
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        r(0, 1); r(0, 0); r(1, 0); r(2, 0); r(3, 1); r(3, 0);
        r(4, 3); r(4, 2); r(4, 1); r(4, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 1, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);

        // B: pause 5 cycles in stage 3 with remaining=1, then resume
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        r(0, 1); r(0, 0); r(1, 0); r(2, 0); r(3, 1);
        v(0, 1, 0, 1, 3, 1, 1, 1, 0, 0);
        v(0, 1, 0, 1, 3, 1, 1, 1, 0, 0);
        v(1, 1, 0, 1, 3, 1, 1, 1, 0, 0);
        v(0, 1, 0, 1, 3, 1, 1, 1, 0, 0);
        v(0, 1, 0, 1, 3, 1, 1, 1, 0, 0);
        v(1, 0, 0, 1, 3, 1, 1, 0, 0, 0);
        r(3, 0); r(4, 3); r(4, 2); r(4, 1); r(4, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 1, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);

        // C: door open 3 cycles in stage 4, start ignored while open
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        r(0, 1); r(0, 0); r(1, 0); r(2, 0); r(3, 1); r(3, 0); r(4, 3);
        v(0, 0, 0, 0, 4, 3, 1, 1, 0, 0);
        v(1, 0, 0, 0, 4, 3, 1, 1, 0, 0);
        v(0, 0, 0, 0, 4, 3, 1, 1, 0, 0);
        v(0, 0, 0, 1, 4, 3, 1, 1, 0, 0);
        v(1, 0, 0, 1, 4, 3, 1, 0, 0, 0);
        r(4, 2); r(4, 1); r(4, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 1, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);

        // D: abort during PAUSE in stage 2, then abort in IDLE
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        r(0, 1); r(0, 0); r(1, 0); r(2, 0);
        v(0, 1, 0, 1, 2, 0, 1, 1, 0, 0);
        v(0, 1, 1, 1, IDL, 0, 0, 0, 0, 1);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);
        v(1, 0, 1, 1, IDL, 0, 0, 0, 0, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);

        // E: pause coinciding with last-stage expiry, resume, done;
        // back-to-back start on the done cycle, start in RUN ignored, abort in RUN
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        r(0, 1); r(0, 0); r(1, 0); r(2, 0); r(3, 1); r(3, 0);
        r(4, 3); r(4, 2); r(4, 1); r(4, 0);
        v(0, 1, 0, 1, 4, 0, 1, 1, 0, 0);
        v(1, 0, 0, 1, 4, 0, 1, 0, 0, 0);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 1, 0);
        v(1, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        v(1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        v(0, 0, 1, 1, IDL, 0, 0, 0, 0, 1);
        v(0, 0, 0, 1, IDL, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        door_closed = 1'b1;
        stage_time  = TIMES_STD;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", outs(), pk(IDL, 0, 0, 0, 0, 0));
        reset = 1'b0;

        build_table();
        for (int i = 0; i < vt.size(); i++) begin
            start       = vt[i].st;
            pause       = vt[i].pa;
            abort       = vt[i].ab;
            door_closed = vt[i].dr;
            step();
            chk($sformatf("vec%0d", i), outs(),
                {vt[i].e_stage, vt[i].e_rem, vt[i].e_busy, vt[i].e_paused,
                 vt[i].e_done, vt[i].e_abort});
        end

        // Asynchronous reset mid-RUN, asserted between edges
        start = 1'b1; pause = 1'b0; abort = 1'b0; door_closed = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_reset_run", outs(), pk(0, 0, 1, 0, 0, 0));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_immediate", outs(), pk(IDL, 0, 0, 0, 0, 0));
        step();
        chk("reset_no_pulse", outs(), pk(IDL, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;

        // All-zero durations: one cycle per stage; later stage_time edits ignored
        stage_time = '0;
        start = 1'b1;
        step();
        chk("zero_s0", outs(), pk(0, 0, 1, 0, 0, 0));
        start = 1'b0;
        stage_time = '1;
        for (int s = 1; s < NS; s++) begin
            step();
            chk($sformatf("zero_s%0d", s), outs(), pk(s, 0, 1, 0, 0, 0));
        end
        step();
        chk("zero_done", outs(), pk(IDL, 0, 0, 0, 1, 0));
        step();
        chk("zero_after", outs(), pk(IDL, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
